// File: rtl/interconnect_cfg_ctrl_pkg.sv
// Shared definitions for the interconnect configuration controller.
//   state_e    : controller FSM states
//   SelW       : width of one interconnect select field
//   MaxSel     : largest legal select value; anything above is a bitstream error
//   LutW       : LUT truth-table width per CLB
//   frame_len(): serial frame length in bits for a given LUT input count
package interconnect_cfg_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StLoad,
    StCommit,
    StDone,
    StError
  } state_e;

  localparam int unsigned SelW   = 5;
  localparam int unsigned MaxSel = 23;
  localparam int unsigned LutW   = 16;

  function automatic int unsigned frame_len(input int unsigned lut_in);
    return lut_in * SelW + LutW;
  endfunction

endpackage

// File: rtl/cfg_frame_shifter.sv
// Serial-to-parallel frame collector for one CLB configuration frame.
// Ports:
//   clk, rst_b     : clock, asynchronous active-low reset
//   clr_i          : synchronous clear of frame register and bit counter
//   shift_en_i     : accept bit_i this cycle (valid && ready)
//   bit_i          : serial bitstream bit, MSB of the frame first
//   frame_o        : collected frame; first received bit ends up in the MSB
//   frame_full_o   : the bit accepted this cycle completes the frame
module cfg_frame_shifter
  import interconnect_cfg_ctrl_pkg::*;
#(
  parameter int unsigned FrameLen = frame_len(4)
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                clr_i,
  input  logic                shift_en_i,
  input  logic                bit_i,
  output logic [FrameLen-1:0] frame_o,
  output logic                frame_full_o
);

  localparam int unsigned CntW = $clog2(FrameLen);

  logic [FrameLen-1:0] frame_q, frame_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                last_bit;

  assign last_bit = (cnt_q == CntW'(FrameLen - 1));

  // The counter parks on the last index; only a clear (COMMIT/ERASE) wraps it.
  always_comb begin
    frame_d = frame_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      frame_d = '0;
      cnt_d   = '0;
    end else if (shift_en_i) begin
      frame_d = {frame_q[FrameLen-2:0], bit_i};
      if (!last_bit) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      frame_q <= '0;
      cnt_q   <= '0;
    end else begin
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
    end
  end

  assign frame_o      = frame_q;
  assign frame_full_o = shift_en_i & last_bit & ~clr_i;

endmodule

// File: rtl/interconnect_cfg_ctrl.sv
// FPGA interconnect configuration controller. Erases the fabric, then loads
// one serial frame per CLB (LUT_IN 5-bit selects, then a 16-bit LUT), checks
// every select and commits it to that CLB's output registers.
// Ports:
//   clk, rst_b           : clock, asynchronous active-low reset
//   start                : begin a full load (honoured in IDLE/DONE/ERROR)
//   cfg_data, cfg_valid  : serial bitstream input
//   cfg_ready            : bit accepted when cfg_valid && cfg_ready
//   prgm_b               : 1 once every CLB is programmed
//   clb_prgm_b           : per-CLB strobe, 0 = CLB committed/enabled
//   interconnect_switch  : 5-bit select per CLB input
//   lut_cfg              : 16-bit truth table per CLB
//   busy, cfg_err        : status
module interconnect_cfg_ctrl
  import interconnect_cfg_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CLB   = 4,
  parameter int unsigned LUT_IN    = 4,
  parameter int unsigned ERASE_CYC = 4
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          start,
  input  logic                          cfg_data,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  output logic                          prgm_b,
  output logic [NUM_CLB-1:0]            clb_prgm_b,
  output logic [NUM_CLB*LUT_IN*SelW-1:0] interconnect_switch,
  output logic [NUM_CLB*LutW-1:0]       lut_cfg,
  output logic                          busy,
  output logic                          cfg_err
);

  localparam int unsigned FrameLen = frame_len(LUT_IN);
  localparam int unsigned SwW      = LUT_IN * SelW;
  localparam int unsigned ClbW     = $clog2(NUM_CLB) + 1;
  localparam int unsigned EraseW   = $clog2(ERASE_CYC) + 1;

  state_e                     state_q, state_d;
  logic [ClbW-1:0]            clb_q, clb_d;
  logic [EraseW-1:0]          erase_q, erase_d;
  logic                       prgm_b_q, prgm_b_d;
  logic [NUM_CLB-1:0]         clb_prgm_b_q, clb_prgm_b_d;
  logic [NUM_CLB*SwW-1:0]     sw_q, sw_d;
  logic [NUM_CLB*LutW-1:0]    lut_q, lut_d;
  logic                       ready_q, ready_d;
  logic                       busy_q, busy_d;
  logic                       err_q, err_d;

  logic                       shift_clr;
  logic [FrameLen-1:0]        frame;
  logic                       frame_full;
  logic                       sel_bad;

  cfg_frame_shifter #(
    .FrameLen (FrameLen)
  ) u_shifter (
    .clk          (clk),
    .rst_b        (rst_b),
    .clr_i        (shift_clr),
    .shift_en_i   (cfg_valid & ready_q),
    .bit_i        (cfg_data),
    .frame_o      (frame),
    .frame_full_o (frame_full)
  );

  // Any out-of-range select rejects the whole frame.
  always_comb begin
    sel_bad = 1'b0;
    for (int unsigned j = 0; j < LUT_IN; j++) begin
      if (frame[LutW + j*SelW +: SelW] > SelW'(MaxSel)) begin
        sel_bad = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    clb_d        = clb_q;
    erase_d      = erase_q;
    prgm_b_d     = prgm_b_q;
    clb_prgm_b_d = clb_prgm_b_q;
    sw_d         = sw_q;
    lut_d        = lut_q;
    err_d        = err_q;
    shift_clr    = 1'b0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d      = StErase;
          prgm_b_d     = 1'b0;
          clb_prgm_b_d = '1;
          sw_d         = '0;
          lut_d        = '0;
          clb_d        = '0;
          erase_d      = '0;
          err_d        = 1'b0;
          shift_clr    = 1'b1;
        end
      end
      StErase: begin
        if (erase_q == EraseW'(ERASE_CYC - 1)) begin
          state_d = StLoad;
        end else begin
          erase_d = erase_q + EraseW'(1);
        end
      end
      StLoad: begin
        if (frame_full) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        shift_clr = 1'b1;
        if (sel_bad) begin
          state_d = StError;
          err_d   = 1'b1;
        end else begin
          for (int unsigned k = 0; k < NUM_CLB; k++) begin
            if (clb_q == ClbW'(k)) begin
              sw_d[k*SwW +: SwW]    = frame[FrameLen-1 -: SwW];
              lut_d[k*LutW +: LutW] = frame[LutW-1:0];
              clb_prgm_b_d[k]       = 1'b0;
            end
          end
          if (clb_q == ClbW'(NUM_CLB - 1)) begin
            state_d  = StDone;
            prgm_b_d = 1'b1;
          end else begin
            state_d = StLoad;
            clb_d   = clb_q + ClbW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    ready_d = (state_d == StLoad);
    busy_d  = (state_d == StErase) || (state_d == StLoad) || (state_d == StCommit);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= StIdle;
      clb_q        <= '0;
      erase_q      <= '0;
      prgm_b_q     <= 1'b0;
      clb_prgm_b_q <= '1;
      sw_q         <= '0;
      lut_q        <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      clb_q        <= clb_d;
      erase_q      <= erase_d;
      prgm_b_q     <= prgm_b_d;
      clb_prgm_b_q <= clb_prgm_b_d;
      sw_q         <= sw_d;
      lut_q        <= lut_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign cfg_ready           = ready_q;
  assign prgm_b              = prgm_b_q;
  assign clb_prgm_b          = clb_prgm_b_q;
  assign interconnect_switch = sw_q;
  assign lut_cfg             = lut_q;
  assign busy                = busy_q;
  assign cfg_err             = err_q;

endmodule

// File: doc/interconnect_cfg_ctrl.md
INTERCONNECT_CFG_CTRL -- requirements
Module: interconnect_cfg_ctrl

Interface
REQ-001 Parameter NUM_CLB, default 4: number of CLBs configured per load.
REQ-002 Parameter LUT_IN, default 4: interconnect units (LUT inputs) per CLB.
REQ-003 Parameter ERASE_CYC, default 4: cycles prgm_b is held low in ERASE.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 rst_b  input  1: reset, asynchronous assert, active-low.
REQ-006 start  input  1: single-cycle request to begin a full configuration load.
REQ-007 cfg_data  input  1: serial bitstream bit, MSB-first per CLB frame.
REQ-008 cfg_valid  input  1: cfg_data valid this cycle.
REQ-009 cfg_ready  output  1: controller accepts a bit this cycle; a bit transfers when cfg_valid && cfg_ready.
REQ-010 prgm_b  output  1: global program-done; 1 = fabric programmed.
REQ-011 clb_prgm_b  output  NUM_CLB: per-CLB program strobe; 0 = CLB enabled.
REQ-012 interconnect_switch  output  NUM_CLB*LUT_IN*5: 5-bit select per interconnect unit, CLB k input j at bits [(k*LUT_IN+j)*5 +: 5].
REQ-013 lut_cfg  output  NUM_CLB*16: 16-bit LUT truth table per CLB, CLB k at [k*16 +: 16].
REQ-014 busy  output  1: high in any state except IDLE, DONE and ERROR.
REQ-015 cfg_err  output  1: high while in ERROR.

Function
REQ-016 FSM states: IDLE, ERASE, LOAD, COMMIT, DONE, ERROR.
REQ-017 IDLE/DONE/ERROR + start -> ERASE; start in ERASE, LOAD or COMMIT is ignored.
REQ-018 On ERASE entry: prgm_b=0, all clb_prgm_b=1, interconnect_switch=0, lut_cfg=0, clb counter=0, bit counter=0, cfg_err=0.
REQ-019 ERASE lasts exactly ERASE_CYC cycles, then -> LOAD.
REQ-020 Frame = LUT_IN*5 + 16 bits (36 at defaults): selects for input LUT_IN-1 down to 0, then LUT bits 15..0, MSB first.
REQ-021 cfg_ready=1 only in LOAD; accepted bits shift into a frame register; cycles without cfg_valid stall without timeout.
REQ-022 When the last frame bit is accepted -> COMMIT (one cycle); cfg_ready=0 in COMMIT.
REQ-023 COMMIT: any 5-bit select >23 -> ERROR, CLB k registers unchanged; else write frame to CLB k fields and drive clb_prgm_b[k]=0 in the same edge.
REQ-024 COMMIT with k<NUM_CLB-1 -> LOAD with k+1 and bit counter 0; with k=NUM_CLB-1 -> DONE.
REQ-025 DONE: prgm_b=1, held until next start or reset.
REQ-026 ERROR: prgm_b stays 0, cfg_err=1; CLBs committed earlier keep clb_prgm_b=0 and their fields; only start or reset exits.
REQ-027 Bit counter width clog2(frame length), wraps only through COMMIT; clb counter width clog2(NUM_CLB)+1.
REQ-028 All outputs registered; no combinational path from cfg_data to any output.

Reset
REQ-029 rst_b=0 forces immediately, including mid-LOAD: state=IDLE, prgm_b=0, clb_prgm_b all 1, interconnect_switch=0, lut_cfg=0, cfg_ready=0, busy=0, cfg_err=0, counters and frame register 0.
REQ-030 The first rising edge after rst_b deasserts evaluates start normally.

Structure
REQ-031 Shared package holds the state enum, the select width (5), the maximum legal select (23) and the frame-length function of LUT_IN.
REQ-032 One sub-module, cfg_frame_shifter (shift register + bit counter + frame_full flag); FSM and output registers stay in the top.

Verification
REQ-033 Reset then start, 4 valid frames (CLB0 selects 0,1,2,3; LUT 16'h8000), cfg_valid continuous -> after 4+4*37 cycles prgm_b=1, clb_prgm_b=4'b0000, CLB0 switch field=5'd3,5'd2,5'd1,5'd0 (input 3..0), lut_cfg[15:0]=16'h8000.
REQ-034 Frame for CLB2 has select 5'd24 -> ERROR, cfg_err=1, clb_prgm_b=4'b1100, CLB2/CLB3 fields 0, prgm_b=0; new start -> ERASE clears all.
REQ-035 cfg_valid toggling every other cycle -> identical final outputs to REQ-033, taking twice as many LOAD cycles.
REQ-036 rst_b pulsed low at bit 20 of CLB1 -> all outputs at reset values asynchronously; next load completes correctly.
REQ-037 start pulsed during LOAD at CLB1 and during COMMIT -> ignored, load finishes as in REQ-033; start in DONE -> prgm_b falls, ERASE rerun.
